// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
// Op codes mirror funct3 of OP (0110011) with funct7=0000001.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
// {hi, lo} is the product accumulator (multiply) or {remainder, dividend/quotient} (divide).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            div,
  input  logic [XLEN-1:0] operand,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
    shifted = {hi_in, lo_in[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    hi_out  = sum[XLEN:1];
    lo_out  = {sum[0], lo_in[XLEN-1:1]};
    if (div) begin
      // remainder stays below the divisor, so diff's top bit is a clean borrow flag
      if (!diff[XLEN]) begin
        hi_out = diff[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b1};
      end else begin
        hi_out = shifted[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M MUL/DIV sequencer beside the EX ALU; iterates on unsigned magnitudes.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip iteration.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic            stall,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(1);

  muldiv_state_e   state, state_next;
  logic [CNT_W-1:0] cnt;
  muldiv_op_e      op_q;
  logic [XLEN-1:0] b_mag, hi, lo, result;
  logic            neg, special;

  muldiv_op_e      op_in;
  logic            a_neg, b_neg, b_zero, overflow_in, special_in, neg_in, accept, last_iter;
  logic [XLEN-1:0] a_mag, b_mag_in;

  logic [XLEN-1:0] hi_ch [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] lo_ch [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] fin_hi, fin_lo, div_pick;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] result_next;

  // operand capture
  always_comb begin
    op_in       = muldiv_op_e'(in_op);
    a_neg       = is_signed_a(op_in) & in_rs1[XLEN-1];
    b_neg       = is_signed_b(op_in) & in_rs2[XLEN-1];
    a_mag       = a_neg ? (~in_rs1 + 1'b1) : in_rs1;
    b_mag_in    = b_neg ? (~in_rs2 + 1'b1) : in_rs2;
    b_zero      = (in_rs2 == '0);
    overflow_in = is_div(op_in) & is_signed_b(op_in) & (in_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                  & (in_rs2 == '1);
    // a zero divisor yields an all-ones quotient, so only the remainder keeps a sign
    if (is_rem(op_in)) neg_in = a_neg;
    else               neg_in = (a_neg ^ b_neg) & ~(is_div(op_in) & b_zero);
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign special_in = is_div(op_in) & (b_zero | overflow_in);
`else
  assign special_in = 1'b0;
`endif

  assign accept    = in_valid & in_ready & ~flush;
  assign last_iter = (state == BUSY) && (cnt == (special ? CNT_EARLY : CNT_LAST));

  assign hi_ch[0] = hi;
  assign lo_ch[0] = lo;
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .div    (is_div(op_q)),
      .operand(b_mag),
      .hi_in  (hi_ch[g]),
      .lo_in  (lo_ch[g]),
      .hi_out (hi_ch[g+1]),
      .lo_out (lo_ch[g+1])
    );
  end

  // sign fix-up on the final iteration's outputs
  always_comb begin
    fin_hi   = special ? hi : hi_ch[BITS_PER_CYCLE];
    fin_lo   = special ? lo : lo_ch[BITS_PER_CYCLE];
    prod     = {fin_hi, fin_lo};
    prod_fix = neg ? (~prod + 1'b1) : prod;
    div_pick = is_rem(op_q) ? fin_hi : fin_lo;
    if (is_div(op_q))       result_next = neg ? (~div_pick + 1'b1) : div_pick;
    else if (op_q == OP_MUL) result_next = prod_fix[XLEN-1:0];
    else                    result_next = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) state_next = IDLE;
    else begin
      case (state)
        IDLE:    if (in_valid) state_next = BUSY;
        BUSY:    if (last_iter) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    stall     = (in_valid & in_ready) | (state == BUSY) | ((state == DONE) & ~out_ready);
  end

  assign out_result = result;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= OP_MUL;
      b_mag   <= '0;
      hi      <= '0;
      lo      <= '0;
      neg     <= 1'b0;
      special <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt     <= '0;
      op_q    <= op_in;
      b_mag   <= b_mag_in;
      neg     <= neg_in;
      special <= special_in;
      // special ops are preloaded so the normal fix-up yields their fixed answer
      if (special_in) begin
        hi <= b_zero ? a_mag : '0;
        lo <= b_zero ? '1 : a_mag;
      end else begin
        hi <= '0;
        lo <= a_mag;
      end
    end else if (state == BUSY) begin
      if (!special) begin
        hi <= hi_ch[BITS_PER_CYCLE];
        lo <= lo_ch[BITS_PER_CYCLE];
      end
      if (last_iter) begin
        cnt    <= '0;
        result <= result_next;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases plus randomized ops
// against a plain-arithmetic reference model. Honours MULDIV_EARLY_OUT_EN for latency.
module tb_muldiv_seq;

  logic        clk = 0;
  logic        rst, in_valid, in_ready, flush, stall, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [31:0] in_rs1, in_rs2, out_result;

  int          vectors = 0;
  int          miscompares = 0;
  logic        started = 0;
  logic        exp_pending = 0;
  logic [31:0] exp_result = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_SP = 2;
`else
  localparam int LAT_SP = 32;
`endif

  muldiv_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .flush(flush), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(ua / ub); return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return LAT_SP;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SP;
    return 32;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // every cycle: a pending result must match the model, otherwise no out_valid
  always @(negedge clk) begin
    if (started) begin
      if (exp_pending && out_valid) chk("result", out_result, exp_result);
      else if (!exp_pending)        chk("no_valid", {31'd0, out_valid}, 32'd0);
    end
  end

  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1; in_op = op; in_rs1 = a; in_rs2 = b;
    @(negedge clk);
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    exp_result = model(op, a, b);
    exp_pending = 1;
  endtask

  task automatic wait_done(input int lat);
    int n;
    n = 0;
    chk("busy_stall", {30'd0, stall, in_ready}, 32'd2);
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
  endtask

  task automatic retire(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid_stall", {30'd0, out_valid, stall}, 32'd3);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    exp_pending = 0;
    chk("idle_after", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    start(op, a, b);
    wait_done(exp_latency(op, a, b));
    retire(hold);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 3));
      3: return 32'($urandom_range(0, 100)) - 32'd50;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    rst = 1; in_valid = 0; flush = 0; out_ready = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    started = 1;
    chk("reset_outputs", {29'd0, in_ready, stall, out_valid}, 32'd4);
    chk("reset_result", out_result, 32'd0);

    // model pins
    chk("pin_mul", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulh", model(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("pin_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div", model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem", model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_divov", model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("pin_remov", model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 1);
    run(3'd3, 32'h8000_0000, 32'h8000_0000, 0);
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run(3'd5, 32'hFFFF_FFFF, 32'd0, 0);
    run(3'd7, 32'h0000_1234, 32'd0, 0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(3'd4, 32'hFFFF_FFF9, 32'd0, 0);
    run(3'd6, 32'hFFFF_FFF9, 32'd0, 0);
    run(3'd0, 32'h0001_0003, 32'h0002_0005, 5);

    // back-to-back: next op presented during the retiring handshake
    start(3'd5, 32'd100, 32'd7);
    wait_done(32);
    out_ready = 1; in_valid = 1; in_op = 3'd0; in_rs1 = 32'd9; in_rs2 = 32'd11;
    @(posedge clk); #1;
    out_ready = 0;
    exp_pending = 0;
    chk("b2b_not_same_cycle", {30'd0, in_ready, out_valid}, 32'd2);
    @(posedge clk); #1;
    in_valid = 0;
    exp_result = 32'd99;
    exp_pending = 1;
    chk("b2b_accepted", {31'd0, in_ready}, 32'd0);
    wait_done(32);
    retire(0);

    // flush at iteration 10
    start(3'd0, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    exp_pending = 0;
    chk("flush_idle", {31'd0, in_ready}, 32'd1);
    // flush in IDLE blocks acceptance
    in_valid = 1; flush = 1; in_op = 3'd0; in_rs1 = 32'd5; in_rs2 = 32'd5;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    chk("flush_blocks_accept", {31'd0, in_ready}, 32'd1);
    // reset at iteration 20 of a second op
    start(3'd4, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_pending = 0;
    chk("rst_mid_op", {30'd0, in_ready, out_valid}, 32'd2);
    chk("rst_mid_result", out_result, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    run(3'd0, 32'd3, 32'd4, 0);
    chk("mul_3x4", out_result, 32'd12);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run(rop, ra, rb, int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
